cms_axis_downsizer: RTL and testbench
=====================================

CMS_AXIS_DOWNSIZER -- requirements
Module: cms_axis_downsizer

Interface
REQ-001 Parameter IN_WIDTH, default 512, width of the slave stream data (the monitoring-system packet width).
REQ-002 Parameter OUT_WIDTH, default 64, width of the master stream data; IN_WIDTH SHALL be an integer multiple of OUT_WIDTH, ratio R = IN_WIDTH/OUT_WIDTH, R >= 2.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port S_AXIS_tvalid  input  1  upstream packet valid.
REQ-006 Port S_AXIS_tready  output  1  downsizer can accept an upstream packet.
REQ-007 Port S_AXIS_tdata  input  IN_WIDTH  upstream packet.
REQ-008 Port S_AXIS_tlast  input  1  upstream end-of-transfer marker.
REQ-009 Port M_AXIS_tvalid  output  1  downstream beat valid.
REQ-010 Port M_AXIS_tready  input  1  downstream sink ready.
REQ-011 Port M_AXIS_tdata  output  OUT_WIDTH  downstream beat.
REQ-012 Port M_AXIS_tlast  output  1  downstream end-of-transfer marker.
REQ-013 Port packet_count  output  32  number of upstream packets accepted (see Configuration).
REQ-014 Port transfer_count  output  32  number of downstream beats sent with M_AXIS_tlast=1 (see Configuration).

Function
REQ-015 State machine SHALL have two states: IDLE (holding register empty) and SEND (holding register occupied).
REQ-016 Upstream transfer occurs when S_AXIS_tvalid && S_AXIS_tready on a rising edge; downstream beat completes when M_AXIS_tvalid && M_AXIS_tready.
REQ-017 In IDLE: S_AXIS_tready=1, M_AXIS_tvalid=0; on upstream transfer, capture tdata and tlast into holding register, beat index := 0, go to SEND.
REQ-018 In SEND: M_AXIS_tvalid=1; M_AXIS_tdata = holding[(index+1)*OUT_WIDTH-1 : index*OUT_WIDTH]; least-significant slice first.
REQ-019 M_AXIS_tlast SHALL be 1 only when index == R-1 and captured tlast == 1; otherwise 0.
REQ-020 Beat completion with index < R-1: index increments by 1, stay in SEND.
REQ-021 Beat completion with index == R-1: if S_AXIS_tvalid, capture the new packet, index := 0, stay in SEND (no bubble); else go to IDLE.
REQ-022 S_AXIS_tready in SEND SHALL equal (index == R-1) && M_AXIS_tready, combinationally.
REQ-023 M_AXIS_tvalid held with M_AXIS_tready=0: tdata, tlast and index SHALL remain stable (AXI-Stream rule); tvalid SHALL NOT deassert.
REQ-024 Latency: packet accepted at edge N yields first beat valid in the cycle after edge N; sustained throughput one beat per cycle, R cycles per packet.
REQ-025 Index width SHALL be clog2(R); no wrap beyond R-1.

Reset
REQ-026 While rst=1: state=IDLE, index=0, holding register=0, captured tlast=0, counters=0, independent of clk.
REQ-027 Reset outputs: S_AXIS_tready=0 while rst asserted, M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, packet_count=0, transfer_count=0.
REQ-028 Reset mid-packet SHALL discard remaining beats; after deassertion the first accepted packet starts at index 0.

Configuration
REQ-029 Macro CMS_DOWNSIZER_STATS_EN: when defined, packet_count increments on each upstream transfer and transfer_count increments on each completed beat with M_AXIS_tlast=1, both 32-bit wrapping 0xFFFFFFFF -> 0.
REQ-030 When CMS_DOWNSIZER_STATS_EN is undefined, no counter registers are built; packet_count and transfer_count SHALL be constant 0; all other behaviour identical.

Verification
REQ-031 Single packet, tdata = {8 x 64-bit} values 0..7 in slices 0..7, tlast=1, M_AXIS_tready=1 -> beats 0,1,...,7 on 8 consecutive cycles, tlast only on beat 7, S_AXIS_tready high in IDLE.
REQ-032 Back-to-back packets A,B with S_AXIS_tvalid held high, sink ready -> 16 consecutive beats without gap, B accepted on A's beat-7 cycle.
REQ-033 Sink stalls: M_AXIS_tready=0 for 5 cycles at beat 3 -> beat 3 data stable for 6 cycles, tvalid stays 1, no upstream accept.
REQ-034 Packet with tlast=0 followed by one with tlast=1 -> 16 beats, M_AXIS_tlast=1 only on beat 15; with STATS_EN packet_count=2, transfer_count=1.
REQ-035 Assert rst at beat 4 of a packet -> outputs zero asynchronously; after release a new packet emits from slice 0.
REQ-036 Build without CMS_DOWNSIZER_STATS_EN, run REQ-032 traffic -> identical beat stream, packet_count=transfer_count=0.

Source files
------------

// File: rtl/cms_axis_downsizer.sv
// cms_axis_downsizer
//   Splits each IN_WIDTH-bit upstream AXI-Stream packet into R = IN_WIDTH/OUT_WIDTH
//   OUT_WIDTH-bit downstream beats, least-significant slice first. A new packet is
//   accepted on the cycle the last beat of the current one completes, so sustained
//   traffic runs at one beat per cycle with no bubble between packets.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   S_AXIS_t*           : upstream stream (tvalid/tready/tdata[IN_WIDTH]/tlast)
//   M_AXIS_t*           : downstream stream (tvalid/tready/tdata[OUT_WIDTH]/tlast)
//   packet_count        : upstream packets accepted (stats build only, else 0)
//   transfer_count      : downstream beats sent with tlast=1 (stats build only, else 0)
//
// Build option
//   CMS_DOWNSIZER_STATS_EN : when defined, builds the two 32-bit wrapping counters.

module cms_axis_downsizer #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [31:0]          packet_count,
  output logic [31:0]          transfer_count
);

  localparam int R     = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(R);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [R-1:0][OUT_WIDTH-1:0] hold_q, hold_d;
  logic                        last_q, last_d;

  logic idx_last;
  logic s_fire;
  logic m_fire;

  assign idx_last      = (idx_q == IDX_LAST);
  assign M_AXIS_tvalid = (state_q == SEND);
  assign M_AXIS_tdata  = hold_q[idx_q];
  assign M_AXIS_tlast  = (state_q == SEND) && idx_last && last_q;
  // Ready is combinational on the sink's ready during the last beat so the next
  // packet can be loaded in the same cycle the final slice leaves.
  assign S_AXIS_tready = !rst && ((state_q == IDLE) || (idx_last && M_AXIS_tready));
  assign s_fire        = S_AXIS_tvalid && S_AXIS_tready;
  assign m_fire        = M_AXIS_tvalid && M_AXIS_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          hold_d  = S_AXIS_tdata;
          last_d  = S_AXIS_tlast;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_fire) begin
          if (!idx_last) begin
            idx_d = idx_q + 1'b1;
          end else if (s_fire) begin
            hold_d = S_AXIS_tdata;
            last_d = S_AXIS_tlast;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

`ifdef CMS_DOWNSIZER_STATS_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + {31'd0, s_fire};
    xfer_cnt_d = xfer_cnt_q + {31'd0, m_fire && M_AXIS_tlast};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign packet_count   = pkt_cnt_q;
  assign transfer_count = xfer_cnt_q;
`else
  assign packet_count   = '0;
  assign transfer_count = '0;
`endif

endmodule

// File: tb/tb_cms_axis_downsizer.sv
module tb_cms_axis_downsizer;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int R     = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [IN_W-1:0]  s_tdata = '0;
  logic             s_tlast = 1'b0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tlast;
  logic [31:0]      packet_count;
  logic [31:0]      transfer_count;

  cms_axis_downsizer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready),
    .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast),
    .packet_count(packet_count), .transfer_count(transfer_count)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int unsigned exp_pkts = 0;
  int unsigned exp_xfers = 0;

  logic [OUT_W:0] exp_q[$];     // {last, data}
  int unsigned    beat_cyc[$];  // cycle stamp of each observed beat

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a beat completes at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got data %h last %0b expected none", m_tdata, m_tlast);
      end else begin
        logic [OUT_W:0] e;
        e = exp_q.pop_front();
        if ({m_tlast, m_tdata} !== e) begin
          failures++;
          $display("FAIL beat: got last %0b data %h expected last %0b data %h",
                   m_tlast, m_tdata, e[OUT_W], e[OUT_W-1:0]);
        end
      end
    end
  end

  function automatic logic [IN_W-1:0] mk_pkt(input int unsigned id);
    logic [IN_W-1:0] d;
    for (int unsigned r = 0; r < R; r++) d[r*OUT_W +: OUT_W] = {32'(id), 32'(r)};
    return d;
  endfunction

  // Present a packet and wait for its handshake; leaves tvalid high so back-to-back
  // calls produce continuous upstream traffic. Returns at accept edge + 1.
  task automatic send_pkt(input logic [IN_W-1:0] d, input logic l);
    bit ok = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    for (int unsigned r = 0; r < R; r++)
      exp_q.push_back({(l && r == R - 1), d[r*OUT_W +: OUT_W]});
    exp_pkts++;
    if (l) exp_xfers++;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (s_tready) ok = 1;
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: got no handshake expected handshake");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_stats(input string name);
`ifdef CMS_DOWNSIZER_STATS_EN
    chk({name, "_pkt_cnt"}, 64'(packet_count), 64'(exp_pkts));
    chk({name, "_xfer_cnt"}, 64'(transfer_count), 64'(exp_xfers));
`else
    chk({name, "_pkt_cnt"}, 64'(packet_count), 64'd0);
    chk({name, "_xfer_cnt"}, 64'(transfer_count), 64'd0);
`endif
  endtask

  task automatic chk_gapless(input string name, input int unsigned n, input int unsigned first);
    chk({name, "_nbeats"}, 64'(beat_cyc.size()), 64'(n));
    if (beat_cyc.size() == n) begin
      chk({name, "_first_cyc"}, 64'(beat_cyc[0]), 64'(first));
      for (int unsigned i = 1; i < n; i++)
        chk({name, "_gap"}, 64'(beat_cyc[i] - beat_cyc[i-1]), 64'd1);
    end
  endtask

  logic [IN_W-1:0] pa, pb, pc;
  int unsigned acc_a;

  initial begin
    // Reset state
    #12;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk_stats("rst");
    @(posedge clk); #1 rst = 1'b0;
    m_tready = 1'b1;
    @(negedge clk);
    chk("idle_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk); #1;

    // Single packet, slices 0..7
    beat_cyc.delete();
    send_pkt(mk_pkt(0), 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk_gapless("single", R, acc_cyc);
    @(negedge clk);
    chk("single_idle_tready", 64'(s_tready), 64'd1);
    chk("single_idle_tvalid", 64'(m_tvalid), 64'd0);
    chk_stats("single");
    @(posedge clk); #1;

    // Back-to-back A,B: 16 gapless beats, B taken on A's last beat
    beat_cyc.delete();
    send_pkt(mk_pkt(32'hA), 1'b1);
    acc_a = acc_cyc;
    send_pkt(mk_pkt(32'hB), 1'b1);
    s_tvalid = 1'b0;
    chk("b2b_accept_spacing", 64'(acc_cyc - acc_a), 64'(R));
    drain();
    chk_gapless("b2b", 2 * R, acc_a);
    chk_stats("b2b");

    // Sink stall at beat 3 for 5 cycles, next packet waiting upstream
    pa = mk_pkt(32'h51);
    pc = mk_pkt(32'h52);
    send_pkt(pa, 1'b1);
    repeat (3) @(posedge clk);
    #1 m_tready = 1'b0;
    s_tdata = pc; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_tvalid", 64'(m_tvalid), 64'd1);
      chk("stall_tdata", m_tdata, pa[3*OUT_W +: OUT_W]);
      chk("stall_tlast", 64'(m_tlast), 64'd0);
      chk("stall_s_tready", 64'(s_tready), 64'd0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    send_pkt(pc, 1'b0);
    s_tvalid = 1'b0;
    drain();

    // tlast=0 then tlast=1: only beat 15 carries tlast
    pb = mk_pkt(32'h61);
    send_pkt(pb, 1'b0);
    send_pkt(mk_pkt(32'h62), 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk_stats("tlast_pair");

    // Reset during beat 4: outputs clear without a clock edge, remaining beats dropped
    send_pkt(mk_pkt(32'h71), 1'b1);
    s_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_tdata", m_tdata, 64'd0);
    chk("mid_rst_tlast", 64'(m_tlast), 64'd0);
    chk("mid_rst_s_tready", 64'(s_tready), 64'd0);
    exp_q.delete();
    exp_pkts = 0; exp_xfers = 0;
    chk_stats("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    beat_cyc.delete();
    send_pkt(mk_pkt(32'h81), 1'b1);
    s_tvalid = 1'b0;
    drain();
    chk_gapless("post_rst", R, acc_cyc);
    chk_stats("post_rst");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
